uart_ctrl: RTL
==============

// Module: uart_ctrl
// PURPOSE
//  Memory-mapped UART controller between the MIPS pipeline data bus and the UART receiver/sender.
//  Buffers received bytes in an RX FIFO and sequences single-byte transmits via a TX FSM.
//  Exposes TXD/RXD/CON registers and an interrupt line to the CPU. All logic on sysclk.
// PARAMETERS
//  DEPTH   4           RX FIFO entries; power of two, >=2
//  PTR_W   2           log2(DEPTH); FIFO pointer width
//  BASE    32'h40000018 address of TXD; RXD=BASE+4, CON=BASE+8
// PORTS
//  sysclk     in   1   system clock, all state on posedge
//  reset      in   1   asynchronous, active-low reset
//  mem_rd     in   1   CPU load strobe, one cycle per access
//  mem_wr     in   1   CPU store strobe, one cycle per access
//  addr       in   32  CPU byte address, word aligned
//  wdata      in   32  CPU store data
//  rdata      out  32  read data, combinational from addr/mem_rd
//  rx_data    in   8   byte from receiver, valid when rx_status pulses
//  rx_status  in   1   one-sysclk pulse: new byte on rx_data
//  tx_status  in   1   sender busy (high while a frame is shifting)
//  tx_data    out  8   byte to sender, stable from tx_en until frame done
//  tx_en      out  1   one-sysclk start pulse to sender
//  irq        out  1   level interrupt to CPU
// BEHAVIOUR
//  Reset: FIFO empty, pointers/count 0; CON=0; tx_data=0; tx_en=0; TX FSM=IDLE; irq=0.
//  Reset mid-frame aborts TX FSM and discards FIFO contents; the sender is not otherwise signalled.
//  Register map (rdata=0 if mem_rd=0 or addr not in map):
//   TXD R/W  [7:0]=last byte written; upper bits read 0.
//   RXD R    [7:0]=FIFO head (0 if empty); read pops head at that sysclk edge; writes ignored.
//   CON R/W  b0 tx_int_en, b1 rx_int_en (RW); b2 tx_done, b5 rx_ovf (sticky, write-1-clear);
//            b3 rx_nempty, b4 tx_busy (RO); other bits read 0, writes ignored.
//  RX path:
//   rx_status & !full -> push rx_data, count+1. rx_status & full -> byte dropped, rx_ovf<=1.
//   Pop when empty: no-op. Push and pop same cycle: both happen, count unchanged
//    (when full, pop makes room: push accepted, no overflow).
//   Pointers wrap modulo DEPTH; count is PTR_W+1 bits, 0..DEPTH.
//  TX FSM (tx_busy = state!=IDLE):
//   IDLE : mem_wr to TXD -> latch wdata[7:0] into tx_data, go START.
//   START: tx_en=1 this cycle only -> WAIT_B.
//   WAIT_B: tx_status=1 -> WAIT_D (sender accepted); else hold.
//   WAIT_D: tx_status=0 -> tx_done<=1, go IDLE.
//   Write to TXD while not IDLE: ignored (TXD and tx_data unchanged).
//   tx_done set and W1C on same cycle: set wins.
//  Latency: TXD write at edge N -> tx_en high in cycle N+1. RXD read returns head combinationally;
//   the next head is visible in the cycle after the pop.
//  irq = (b1 & rx_nempty) | (b0 & tx_done), registered; it follows its inputs one cycle later.
//  Simultaneous mem_rd and mem_wr: both honoured independently.
// STRUCTURE
//  Shared package uart_defs: TXD/RXD/CON offsets, CON bit indices, TX state encoding
//   (IDLE=0, START=1, WAIT_B=2, WAIT_D=3).
//  Sub-module uart_rx_fifo (DEPTH/PTR_W; push, pop, din, dout, full, empty, count).
//   Register decode and the TX FSM stay in uart_ctrl.
// TESTING
//  1. Pulse rx_status with 0x41, then 0x42; read RXD twice -> 0x41 then 0x42.
//     CON b3 is then 0; the third read returns 0.
//  2. Push 5 bytes 0x01..0x05 without reads -> CON b5=1; reads yield 0x01..0x04.
//     Write CON=0x20 -> b5 clears.
//  3. FIFO full plus a simultaneous rx_status pulse and RXD read -> no overflow; count stays 4.
//     The new byte is last out.
//  4. Write TXD=0x55 -> tx_en pulses exactly one cycle later and tx_data=0x55.
//     Model tx_status high for 20 cycles, then low -> CON b2=1, b4=0.
//  5. Write TXD=0x66 while busy -> TXD reads 0x55 and no extra tx_en.
//     CON=0x01 with tx_done set -> irq=1; write CON=0x05 -> irq drops.
//  6. Assert reset low mid-WAIT_D with 2 bytes buffered -> all outputs at reset values
//     immediately (async); FIFO reads empty after release.

Source files
------------

// File: rtl/uart_defs.sv
// uart_defs: register offsets, CON bit positions and TX state encoding shared by the UART controller
package uart_defs;
  localparam logic [31:0] TXD_OFF = 32'h0;
  localparam logic [31:0] RXD_OFF = 32'h4;
  localparam logic [31:0] CON_OFF = 32'h8;
  localparam int CON_TX_IE     = 0;
  localparam int CON_RX_IE     = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_NEMPTY = 3;
  localparam int CON_TX_BUSY   = 4;
  localparam int CON_RX_OVF    = 5;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    WAIT_B = 2'd2,
    WAIT_D = 2'd3
  } tx_state_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small receive byte FIFO; a pop on a full FIFO frees room for a same-cycle push
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == (PTR_W+1)'(DEPTH);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? 8'h00 : mem[rd_ptr];
  // pointers and occupancy; wrap naturally modulo DEPTH
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  // storage needs no reset: empty masks stale entries
  always_ff @(posedge sysclk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped UART controller with RX FIFO, single-byte TX sequencer and interrupt
module uart_ctrl import uart_defs::*; #(
  parameter int          DEPTH = 4,
  parameter int          PTR_W = 2,
  parameter logic [31:0] BASE  = 32'h40000018
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_status,
  input  logic        tx_status,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        irq
);
  tx_state_t      state, next;
  logic           sel_txd, sel_rxd, sel_con;
  logic           wr_txd, wr_con, rd_rxd;
  logic           tx_ie, rx_ie, tx_done, rx_ovf;
  logic           tx_busy, frame_done, ovf_set;
  logic           fifo_full, fifo_empty;
  logic [7:0]     fifo_dout;
  logic [PTR_W:0] fifo_count;
  logic [31:0]    con;
  logic           unused_bits;
  assign sel_txd     = addr == BASE + TXD_OFF;
  assign sel_rxd     = addr == BASE + RXD_OFF;
  assign sel_con     = addr == BASE + CON_OFF;
  assign wr_txd      = mem_wr & sel_txd;
  assign wr_con      = mem_wr & sel_con;
  assign rd_rxd      = mem_rd & sel_rxd;
  assign ovf_set     = rx_status & fifo_full & ~rd_rxd;
  assign unused_bits = ^{wdata[31:8], fifo_count};
  uart_rx_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .sysclk(sysclk),
    .reset(reset),
    .push(rx_status),
    .pop(rd_rxd),
    .din(rx_data),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  // TX state register
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  // TX next state: start on TXD write, wait for sender to go busy, then idle again
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (wr_txd) next = START;
      START:   next = WAIT_B;
      WAIT_B:  if (tx_status) next = WAIT_D;
      WAIT_D:  if (!tx_status) next = IDLE;
      default: next = IDLE;
    endcase
  end
  // TX outputs decoded from state
  always_comb begin
    tx_en      = state == START;
    tx_busy    = state != IDLE;
    frame_done = (state == WAIT_D) & ~tx_status;
  end
  // outgoing byte latched only when idle so it stays stable for the whole frame
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) tx_data <= 8'h00;
    else if (wr_txd && state == IDLE) tx_data <= wdata[7:0];
  // control/status bits; sticky flags give priority to a new event over a clear
  always_ff @(posedge sysclk or negedge reset)
    if (!reset) begin
      tx_ie   <= 1'b0;
      rx_ie   <= 1'b0;
      tx_done <= 1'b0;
      rx_ovf  <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_con) begin
        tx_ie <= wdata[CON_TX_IE];
        rx_ie <= wdata[CON_RX_IE];
      end
      tx_done <= frame_done | (tx_done & ~(wr_con & wdata[CON_TX_DONE]));
      rx_ovf  <= ovf_set | (rx_ovf & ~(wr_con & wdata[CON_RX_OVF]));
      irq     <= (rx_ie & ~fifo_empty) | (tx_ie & tx_done);
    end
  // CON read image
  always_comb begin
    con                = '0;
    con[CON_TX_IE]     = tx_ie;
    con[CON_RX_IE]     = rx_ie;
    con[CON_TX_DONE]   = tx_done;
    con[CON_RX_NEMPTY] = ~fifo_empty;
    con[CON_TX_BUSY]   = tx_busy;
    con[CON_RX_OVF]    = rx_ovf;
  end
  // combinational read mux
  always_comb
    rdata = !mem_rd ? 32'h0 :
            sel_txd ? {24'h0, tx_data} :
            sel_rxd ? {24'h0, fifo_dout} :
            sel_con ? con : 32'h0;
endmodule
